// File: rtl/controle_servo_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel servo controller.
// Pulse-width table and counter sizing are pure constant functions.
package controle_servo_pkg;

  typedef enum logic {
    PARADO  = 1'b0,
    MOVENDO = 1'b1
  } estado_servo_t;

  function automatic int larg_contador(input int periodo);
    return (periodo > 2) ? $clog2(periodo) : 1;
  endfunction

  // Linear map of position p onto [larg_min, larg_max], remainder discarded.
  function automatic int largura_de(input int p, input int larg_pos,
                                    input int larg_min, input int larg_max);
    return larg_min + (p * (larg_max - larg_min)) / ((1 << larg_pos) - 1);
  endfunction

endpackage

// File: rtl/controle_servo_multi_canal.sv
// One servo channel: target/current width registers, optional per-frame slew
// limit (CONTROLE_SERVO_RAMPA_EN), PWM comparator and pronto flag.
//
// state   | meaning
// PARADO  | current width equals target width
// MOVENDO | current width still ramping toward target
module canal_servo
  import controle_servo_pkg::*;
#(
  parameter int LARG_POS     = 2,
  parameter int CONF_PERIODO = 1_000_000,
  parameter int LARG_MIN     = 50_000,
  parameter int LARG_MAX     = 100_000
`ifdef CONTROLE_SERVO_RAMPA_EN
  , parameter int PASSO      = 5_000
`endif
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [larg_contador(CONF_PERIODO)-1:0] contador,
  input  logic                                   amostra,
  input  logic [LARG_POS-1:0]                    posicao,
  output logic                                   controle,
  output logic                                   pronto
);

  localparam int W    = larg_contador(CONF_PERIODO);
  localparam int NPOS = 1 << LARG_POS;
  localparam logic [W-1:0] LMIN = W'(LARG_MIN);

  logic [W-1:0] tabela [NPOS];

  for (genvar p = 0; p < NPOS; p++) begin : g_tabela
    assign tabela[p] = W'(largura_de(p, LARG_POS, LARG_MIN, LARG_MAX));
  end

  estado_servo_t estado, estado_prox;
  logic [W-1:0]  alvo, atual, alvo_novo, atual_prox;
`ifdef CONTROLE_SERVO_RAMPA_EN
  logic [W-1:0]  dif;
`endif

  always_comb begin
    alvo_novo = tabela[posicao];
`ifdef CONTROLE_SERVO_RAMPA_EN
    dif = (alvo_novo >= atual) ? (alvo_novo - atual) : (atual - alvo_novo);
    // A step larger than dif only happens when dif <= PASSO, so the
    // truncated PASSO below never wraps.
    if (int'(dif) <= PASSO)
      atual_prox = alvo_novo;
    else if (alvo_novo > atual)
      atual_prox = atual + W'(PASSO);
    else
      atual_prox = atual - W'(PASSO);
`else
    atual_prox = alvo_novo;
`endif
    estado_prox = (atual == alvo) ? PARADO : MOVENDO;
    if (amostra)
      estado_prox = (atual_prox == alvo_novo) ? PARADO : MOVENDO;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      estado <= PARADO;
    else
      estado <= estado_prox;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alvo     <= LMIN;
      atual    <= LMIN;
      controle <= 1'b0;
    end else begin
      controle <= (contador < atual);
      if (amostra) begin
        alvo  <= alvo_novo;
        atual <= atual_prox;
      end
    end
  end

  assign pronto = (estado == PARADO);

endmodule

// File: rtl/controle_servo_multi.sv
// Multi-channel servo PWM controller: shared frame counter, one canal_servo per
// channel. Slew limiting is enabled by defining CONTROLE_SERVO_RAMPA_EN.
module controle_servo_multi
  import controle_servo_pkg::*;
#(
  parameter int CANAIS       = 2,
  parameter int LARG_POS     = 2,
  parameter int CONF_PERIODO = 1_000_000,
  parameter int LARG_MIN     = 50_000,
  parameter int LARG_MAX     = 100_000,
  parameter int PASSO        = 5_000,
  parameter int DB_CANAL     = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CANAIS*LARG_POS-1:0]   posicao,
  output logic [CANAIS-1:0]            controle,
  output logic                         db_controle,
  output logic [CANAIS-1:0]            pronto,
  output logic                         fim_periodo
);

  localparam int W = larg_contador(CONF_PERIODO);
  localparam logic [W-1:0] ULTIMO = W'(CONF_PERIODO - 1);

  if (CANAIS < 1 || CANAIS > 8) begin : g_erro_canais
    $fatal(1, "controle_servo_multi: CANAIS must be 1..8");
  end
  if (LARG_MIN < 0 || LARG_MIN > LARG_MAX || LARG_MAX >= CONF_PERIODO) begin : g_erro_larg
    $fatal(1, "controle_servo_multi: need 0 <= LARG_MIN <= LARG_MAX < CONF_PERIODO");
  end
  if (PASSO < 1) begin : g_erro_passo
    $fatal(1, "controle_servo_multi: PASSO must be >= 1");
  end
  if (DB_CANAL < 0 || DB_CANAL >= CANAIS) begin : g_erro_db
    $fatal(1, "controle_servo_multi: DB_CANAL must be < CANAIS");
  end

  logic [W-1:0] contador;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      contador <= '0;
    else if (fim_periodo)
      contador <= '0;
    else
      contador <= contador + W'(1);
  end

  assign fim_periodo = (contador == ULTIMO);

  for (genvar i = 0; i < CANAIS; i++) begin : g_canal
    canal_servo #(
      .LARG_POS     (LARG_POS),
      .CONF_PERIODO (CONF_PERIODO),
      .LARG_MIN     (LARG_MIN),
      .LARG_MAX     (LARG_MAX)
`ifdef CONTROLE_SERVO_RAMPA_EN
      , .PASSO      (PASSO)
`endif
    ) u_canal (
      .clock    (clock),
      .reset    (reset),
      .contador (contador),
      .amostra  (fim_periodo),
      .posicao  (posicao[i*LARG_POS +: LARG_POS]),
      .controle (controle[i]),
      .pronto   (pronto[i])
    );
  end

  assign db_controle = controle[DB_CANAL];

endmodule

// File: tb/tb_controle_servo_multi.sv
// Directed self-checking bench for controle_servo_multi (100-clock frames,
// widths 10..80); expectations follow CONTROLE_SERVO_RAMPA_EN when defined.
module tb_controle_servo_multi;

  localparam int CANAIS       = 2;
  localparam int LARG_POS     = 3;
  localparam int CONF_PERIODO = 100;
  localparam int LARG_MIN     = 10;
  localparam int LARG_MAX     = 80;
  localparam int PASSO        = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  posicao;
  logic [1:0]  controle;
  logic        db_controle;
  logic [1:0]  pronto;
  logic        fim_periodo;

  int vecs = 0;
  int errs = 0;

  always #5 clock = ~clock;

  controle_servo_multi #(
    .CANAIS       (CANAIS),
    .LARG_POS     (LARG_POS),
    .CONF_PERIODO (CONF_PERIODO),
    .LARG_MIN     (LARG_MIN),
    .LARG_MAX     (LARG_MAX),
    .PASSO        (PASSO),
    .DB_CANAL     (0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .posicao     (posicao),
    .controle    (controle),
    .db_controle (db_controle),
    .pronto      (pronto),
    .fim_periodo (fim_periodo)
  );

  // Waits for the boundary negedge, then samples one full frame.
  task automatic measure(output int w0, output int w1, output int wd,
                         output logic [1:0] rdy, output int nf);
    int n;
    n = 0;
    while (!fim_periodo && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!fim_periodo) begin
      vecs++;
      errs++;
      $display("FAIL frame_sync: no fim_periodo within %0d clocks, wanted one", n);
    end
    w0 = 0; w1 = 0; wd = 0; nf = 0; rdy = 2'b00;
    for (int k = 0; k < CONF_PERIODO; k++) begin
      @(negedge clock);
      if (k == 0) rdy = pronto;
      w0 += int'(controle[0]);
      w1 += int'(controle[1]);
      wd += int'(db_controle);
      nf += int'(fim_periodo);
    end
  endtask

  task automatic test_reset;
    int w0, w1, wd, nf, n;
    logic [1:0] rdy;
    reset   = 1'b1;
    posicao = '0;
    repeat (3) @(negedge clock);
    vecs++; if (controle !== 2'b00) begin errs++; $display("FAIL rst_controle: got %b want 00", controle); end
    vecs++; if (db_controle !== 1'b0) begin errs++; $display("FAIL rst_db: got %b want 0", db_controle); end
    vecs++; if (pronto !== 2'b11) begin errs++; $display("FAIL rst_pronto: got %b want 11", pronto); end
    vecs++; if (fim_periodo !== 1'b0) begin errs++; $display("FAIL rst_fim: got %b want 0", fim_periodo); end
    reset = 1'b0;
    n = 0;
    while (!fim_periodo && n < 300) begin
      @(negedge clock);
      n++;
    end
    vecs++; if (n != 99) begin errs++; $display("FAIL rst_first_fim: got %0d clocks want 99", n); end
    for (int f = 0; f < 2; f++) begin
      measure(w0, w1, wd, rdy, nf);
      vecs++; if (w0 != 10) begin errs++; $display("FAIL rst_w0[%0d]: got %0d want 10", f, w0); end
      vecs++; if (w1 != 10) begin errs++; $display("FAIL rst_w1[%0d]: got %0d want 10", f, w1); end
      vecs++; if (wd != 10) begin errs++; $display("FAIL rst_db_w[%0d]: got %0d want 10", f, wd); end
      vecs++; if (rdy !== 2'b11) begin errs++; $display("FAIL rst_rdy[%0d]: got %b want 11", f, rdy); end
      vecs++; if (nf != 1) begin errs++; $display("FAIL rst_fim_count[%0d]: got %0d want 1", f, nf); end
    end
  endtask

  task automatic test_mid_frame;
    int w0, w1, wd, nf, hi1;
    logic [1:0] rdy;
    hi1 = 0;
    for (int k = 1; k <= CONF_PERIODO; k++) begin
      @(negedge clock);
      if (k == 51) posicao[5:3] = 3'd5;
      if (k == 61) posicao[5:3] = 3'd0;
      hi1 += int'(controle[1]);
    end
    vecs++; if (hi1 != 10) begin errs++; $display("FAIL mid_same_frame_w1: got %0d want 10", hi1); end
    measure(w0, w1, wd, rdy, nf);
    vecs++; if (w1 != 10) begin errs++; $display("FAIL mid_next_w1: got %0d want 10", w1); end
    vecs++; if (w0 != 10) begin errs++; $display("FAIL mid_next_w0: got %0d want 10", w0); end
    vecs++; if (rdy !== 2'b11) begin errs++; $display("FAIL mid_rdy: got %b want 11", rdy); end
  endtask

  task automatic test_reversal;
    int w0, w1, wd, nf;
    logic [1:0] rdy;
`ifdef CONTROLE_SERVO_RAMPA_EN
    int   exp_w[4] = '{25, 40, 25, 10};
    logic exp_r[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
    int   exp_w[4] = '{80, 80, 10, 10};
    logic exp_r[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    posicao[2:0] = 3'd7;
    for (int f = 0; f < 4; f++) begin
      measure(w0, w1, wd, rdy, nf);
      vecs++; if (w0 != exp_w[f]) begin errs++; $display("FAIL rev_w0[%0d]: got %0d want %0d", f, w0, exp_w[f]); end
      vecs++; if (rdy[0] !== exp_r[f]) begin errs++; $display("FAIL rev_rdy0[%0d]: got %b want %b", f, rdy[0], exp_r[f]); end
      vecs++; if (w1 != 10) begin errs++; $display("FAIL rev_w1[%0d]: got %0d want 10", f, w1); end
      if (f == 1) posicao[2:0] = 3'd0;
    end
  endtask

  task automatic test_ramp;
    int w0, w1, wd, nf;
    logic [1:0] rdy;
`ifdef CONTROLE_SERVO_RAMPA_EN
    int   exp_w[5] = '{25, 40, 55, 70, 80};
    logic exp_r[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    int   exp_w[5] = '{80, 80, 80, 80, 80};
    logic exp_r[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    posicao[2:0] = 3'd7;
    for (int f = 0; f < 5; f++) begin
      measure(w0, w1, wd, rdy, nf);
      vecs++; if (w0 != exp_w[f]) begin errs++; $display("FAIL ramp_w0[%0d]: got %0d want %0d", f, w0, exp_w[f]); end
      vecs++; if (wd != exp_w[f]) begin errs++; $display("FAIL ramp_db[%0d]: got %0d want %0d", f, wd, exp_w[f]); end
      vecs++; if (rdy[0] !== exp_r[f]) begin errs++; $display("FAIL ramp_rdy0[%0d]: got %b want %b", f, rdy[0], exp_r[f]); end
      vecs++; if (w1 != 10 || rdy[1] !== 1'b1) begin errs++; $display("FAIL ramp_ch1[%0d]: got w=%0d rdy=%b want w=10 rdy=1", f, w1, rdy[1]); end
    end
  endtask

  task automatic test_reset_mid_pulse;
    int w0, w1, wd, nf, n;
    logic [1:0] rdy;
    posicao[2:0] = 3'd3;
    w0 = 0;
    rdy = 2'b00;
    for (int f = 0; f < 8; f++) begin
      measure(w0, w1, wd, rdy, nf);
      if (w0 == 40 && rdy[0] === 1'b1) break;
    end
    vecs++; if (w0 != 40) begin errs++; $display("FAIL pre_rst_w0: got %0d want 40", w0); end
    repeat (6) @(negedge clock);
    vecs++; if (controle[0] !== 1'b1) begin errs++; $display("FAIL pre_rst_high: got %b want 1", controle[0]); end
    reset = 1'b1;
    #1;
    vecs++; if (controle !== 2'b00) begin errs++; $display("FAIL async_rst_controle: got %b want 00", controle); end
    vecs++; if (db_controle !== 1'b0) begin errs++; $display("FAIL async_rst_db: got %b want 0", db_controle); end
    vecs++; if (pronto !== 2'b11 || fim_periodo !== 1'b0) begin errs++; $display("FAIL async_rst_flags: got pronto=%b fim=%b want 11/0", pronto, fim_periodo); end
    posicao = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    n = 0;
    while (!fim_periodo && n < 300) begin
      @(negedge clock);
      n++;
    end
    vecs++; if (n != 99) begin errs++; $display("FAIL post_rst_fim: got %0d clocks want 99", n); end
    measure(w0, w1, wd, rdy, nf);
    vecs++; if (w0 != 10 || w1 != 10) begin errs++; $display("FAIL post_rst_w: got %0d/%0d want 10/10", w0, w1); end
    vecs++; if (rdy !== 2'b11) begin errs++; $display("FAIL post_rst_rdy: got %b want 11", rdy); end
  endtask

  initial begin
    test_reset;
    test_mid_frame;
    test_reversal;
    test_ramp;
    test_reset_mid_pulse;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/controle_servo_multi.md
Name: controle_servo_multi

Overview:
Parametrised multi-channel successor to the single-channel servo controller. Drives CANAIS servo PWM outputs from one shared frame counter. Each channel maps an LARG_POS-bit position onto a linear pulse-width table between LARG_MIN and LARG_MAX. An optional per-frame slew limit ramps each pulse width toward its target, so servos do not jump. Sits between the game/control FSM (which issues positions) and the servo pins, with a debug copy of one channel.

Parameters:
CANAIS, 2, number of independent servo channels (1..8)
LARG_POS, 2, position bits per channel; 2^LARG_POS positions
CONF_PERIODO, 1_000_000, PWM frame length in clocks (20 ms at 50 MHz)
LARG_MIN, 50_000, pulse width in clocks for position 0
LARG_MAX, 100_000, pulse width in clocks for position 2^LARG_POS-1
PASSO, 5_000, maximum width change per frame in clocks (ramp mode only)
DB_CANAL, 0, channel mirrored on db_controle

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
posicao  in  CANAIS*LARG_POS  target positions; channel i occupies bits [i*LARG_POS +: LARG_POS]
controle  out  CANAIS  PWM output per channel
db_controle  out  1  copy of controle[DB_CANAL]
pronto  out  CANAIS  1 when the channel's current width equals its target width
fim_periodo  out  1  one-clock pulse on the last clock of each frame

Behaviour:
- Reset is asynchronous and active-high, with one clock domain. While reset is asserted:
  - frame counter = 0; all targets and current widths = LARG_MIN.
  - controle = 0 and db_controle = 0, taking effect immediately, also when reset arrives mid-pulse.
  - pronto = all 1s; fim_periodo = 0.
- Width table, computed at elaboration: largura(p) = LARG_MIN + p*(LARG_MAX-LARG_MIN)/(2^LARG_POS-1), using integer division with the remainder discarded.
- Widths and the counter are $clog2(CONF_PERIODO) bits, unsigned.
- Frame counter counts 0..CONF_PERIODO-1 and wraps to 0.
- fim_periodo = 1 exactly when counter == CONF_PERIODO-1.
- Output rule: controle[i] = 1 when counter < atual[i]. controle is registered, so it lags the counter by one clock.
- Sampling: posicao is sampled only when counter == CONF_PERIODO-1.
  - On that clock, alvo[i] = largura(posicao_i) and atual[i] is updated (see update rule).
  - The new width applies from counter 0 of the next frame. Changes to posicao within a frame before that clock have no effect.
- Per-channel state is two states, PARADO (atual == alvo) and MOVENDO (atual != alvo).
  - pronto[i] = 1 in PARADO.
  - PARADO moves to MOVENDO at the frame boundary when the new target differs from atual.
  - MOVENDO moves to PARADO at the frame boundary where atual reaches alvo.
- Update rule at the frame boundary, with the ramp enabled:
  - if |alvo_new - atual| <= PASSO, then atual = alvo_new;
  - else atual moves PASSO toward alvo_new.
  - Use a magnitude comparison on the unsigned values; there is no signed wrap.
- Target reversal mid-ramp: the channel ramps from its current atual toward the new target, with no restart from an endpoint.
- Elaboration checks, each a fatal error if violated: LARG_MIN <= LARG_MAX < CONF_PERIODO; PASSO >= 1; DB_CANAL < CANAIS.
- Width 0 (LARG_MIN = 0) is legal and gives a constant-low output. The output is never constant-high.

Optional Feature:
Macro CONTROLE_SERVO_RAMPA_EN.
- Defined: slew limiting by PASSO per frame, as above.
- Not defined: atual = alvo_new at every frame boundary. The PASSO parameter is accepted but unused. pronto can deassert only on the boundary clock itself, which is one clock of MOVENDO folded away, so pronto stays 1 outside reset.

Decomposition:
- Package controle_servo_pkg holds:
  - the width-table function largura_de(p, LARG_POS, LARG_MIN, LARG_MAX);
  - the state typedef estado_servo_t {PARADO, MOVENDO};
  - a function for the counter width.
- Sub-module canal_servo holds one channel: the alvo/atual registers, the ramp, the comparator and the pronto output. It is instantiated CANAIS times in a generate loop. The top level owns the frame counter and fim_periodo.

Test Plan:
All scenarios use CONF_PERIODO=100, LARG_POS=3, LARG_MIN=10, LARG_MAX=80, PASSO=15, CANAIS=2, giving widths 10,20,...,80.
1. Reset, release, posicao=0 -> controle=00 during reset; each frame afterwards, each channel is high for 10 clocks; pronto=11; fim_periodo pulses every 100 clocks.
2. Ramp defined, ch0 posicao=7 set before a boundary -> ch0 high widths over the next frames are 25,40,55,70,80; pronto[0]=0 until the frame at 80, then 1; ch1 is unaffected.
3. Ramp undefined, same stimulus -> the next frame's width is 80; pronto[0] stays 1.
4. posicao ch1 changes to 5 at counter=50, then back to 0 at counter=60 -> ch1 width stays 10 and no boundary effect occurs.
5. Ramp defined, ch0 target 7 for two boundaries, then 0 -> widths 25,40,25,10; pronto[0] rises at 10.
6. Reset asserted at counter=5 of a 40-wide pulse -> controle[0] goes low in the same clock; after release, width is 10 and the counter restarts from 0.
